// File: rtl/cvxif_arb_pkg.sv
// cvxif_arb_pkg: shared types for the CV-X-IF coprocessor arbiter.
// Holds the issue FSM state and the outstanding-table entry.
package cvxif_arb_pkg;

  localparam int unsigned OwnerW = 2;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    RESP
  } issue_state_e;

  typedef struct packed {
    logic              valid;
    logic [OwnerW-1:0] owner;
  } ot_entry_t;

endpackage

// File: rtl/cvxif_coproc_arbiter_rr.sv
// cvxif_result_rr: round-robin result grant with stall lock.
// Priority starts at ptr_q; a stalled grant is held until consumed.
module cvxif_result_rr #(
  parameter int unsigned NrCoproc = 2,
  parameter int unsigned IdxW     = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NrCoproc-1:0] req_i,
  input  logic                stall_i,
  input  logic                advance_i,
  output logic                gnt_vld_o,
  output logic [IdxW-1:0]     gnt_idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            lock_q;
  logic [IdxW-1:0] pick_idx;
  logic            pick_vld;

  // Scan from the farthest slot back so the nearest requester wins.
  always_comb begin
    int c;
    c        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = int'(NrCoproc) - 1; i >= 0; i--) begin
      c = int'(ptr_q) + i;
      if (c >= int'(NrCoproc)) c = c - int'(NrCoproc);
      if (req_i[IdxW'(c)]) begin
        pick_vld = 1'b1;
        pick_idx = IdxW'(c);
      end
    end
  end

  assign gnt_idx_o = lock_q ? lock_idx_q : pick_idx;
  assign gnt_vld_o = lock_q ? req_i[lock_idx_q] : pick_vld;

  // Pointer moves past the consumed source; lock follows the stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= stall_i;
      if (stall_i) lock_idx_q <= gnt_idx_o;
      if (advance_i) begin
        if (gnt_idx_o == IdxW'(NrCoproc - 1)) ptr_q <= '0;
        else ptr_q <= gnt_idx_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cvxif_coproc_arbiter.sv
// cvxif_coproc_arbiter: sequential issue probe and result merge.
// CVXIF_ARB_PERF_EN adds saturating accept/reject counters.
module cvxif_coproc_arbiter
  import cvxif_arb_pkg::*;
#(
  parameter int unsigned NrCoproc = 2,
  parameter int unsigned IdWidth  = 3,
  parameter int unsigned XLEN     = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  logic [31:0]                        issue_instr_i,
  input  logic [IdWidth-1:0]                 issue_id_i,
  output logic                               issue_accept_o,
  output logic                               issue_writeback_o,
  output logic [NrCoproc-1:0]                cp_issue_valid_o,
  input  logic [NrCoproc-1:0]                cp_issue_ready_i,
  input  logic [NrCoproc-1:0]                cp_issue_accept_i,
  input  logic [NrCoproc-1:0]                cp_issue_writeback_i,
  output logic [31:0]                        cp_issue_instr_o,
  output logic [IdWidth-1:0]                 cp_issue_id_o,
  input  logic [NrCoproc-1:0]                cp_result_valid_i,
  output logic [NrCoproc-1:0]                cp_result_ready_o,
  input  logic [NrCoproc-1:0][IdWidth-1:0]   cp_result_id_i,
  input  logic [NrCoproc-1:0][XLEN-1:0]      cp_result_data_i,
  input  logic [NrCoproc-1:0][4:0]           cp_result_rd_i,
  input  logic [NrCoproc-1:0]                cp_result_we_i,
  output logic                               result_valid_o,
  input  logic                               result_ready_i,
  output logic [IdWidth-1:0]                 result_id_o,
  output logic [XLEN-1:0]                    result_data_o,
  output logic [4:0]                         result_rd_o,
  output logic                               result_we_o,
  output logic                               spurious_o,
  output logic [15:0]                        perf_accept_cnt_o,
  output logic [15:0]                        perf_reject_cnt_o
);

  localparam int unsigned IdxW  = $clog2(NrCoproc);
  localparam int unsigned NrIds = 2 ** IdWidth;

  issue_state_e         state_q, state_d;
  logic [IdxW-1:0]      k_q, k_d;
  logic                 acc_q, acc_d;
  logic                 wb_q, wb_d;
  logic [31:0]          instr_q;
  logic [IdWidth-1:0]   id_q;
  logic                 lat_en;
  logic                 set_en;
  ot_entry_t [NrIds-1:0] ot_q;

  logic [IdxW-1:0]      gnt_idx;
  logic                 gnt_vld;
  logic [IdWidth-1:0]   src_id;
  ot_entry_t            src_ent;
  logic                 legit;
  logic                 res_hs;
  logic                 drop;
  logic                 stall;

  assign cp_issue_instr_o = instr_q;
  assign cp_issue_id_o    = id_q;

  // Issue FSM: probe coprocessors in index order, answer in RESP.
  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    acc_d             = acc_q;
    wb_d              = wb_q;
    lat_en            = 1'b0;
    set_en            = 1'b0;
    cp_issue_valid_o  = '0;
    issue_ready_o     = 1'b0;
    issue_accept_o    = 1'b0;
    issue_writeback_o = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      k_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue_valid_i) begin
            lat_en = 1'b1;
            k_d    = '0;
            if (ot_q[issue_id_i].valid) begin
              acc_d   = 1'b0;
              wb_d    = 1'b0;
              state_d = RESP;
            end else begin
              state_d = PROBE;
            end
          end
        end
        PROBE: begin
          cp_issue_valid_o[k_q] = 1'b1;
          if (cp_issue_ready_i[k_q]) begin
            if (cp_issue_accept_i[k_q]) begin
              set_en  = 1'b1;
              acc_d   = 1'b1;
              wb_d    = cp_issue_writeback_i[k_q];
              state_d = RESP;
            end else if (k_q == IdxW'(NrCoproc - 1)) begin
              acc_d   = 1'b0;
              wb_d    = 1'b0;
              state_d = RESP;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        RESP: begin
          issue_ready_o     = 1'b1;
          issue_accept_o    = acc_q;
          issue_writeback_o = wb_q;
          k_d               = '0;
          state_d           = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Issue state, probe index and the captured instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= 1'b0;
      wb_q    <= 1'b0;
      instr_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      wb_q    <= wb_d;
      if (lat_en) begin
        instr_q <= issue_instr_i;
        id_q    <= issue_id_i;
      end
    end
  end

  cvxif_result_rr #(
    .NrCoproc (NrCoproc),
    .IdxW     (IdxW)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (cp_result_valid_i),
    .stall_i   (stall),
    .advance_i (res_hs | drop),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign src_id  = cp_result_id_i[gnt_idx];
  assign src_ent = ot_q[src_id];
  assign legit   = src_ent.valid &&
                   (src_ent.owner == OwnerW'(gnt_idx));

  assign result_valid_o = gnt_vld && legit;
  assign result_id_o    = src_id;
  assign result_data_o  = cp_result_data_i[gnt_idx];
  assign result_rd_o    = cp_result_rd_i[gnt_idx];
  assign result_we_o    = cp_result_we_i[gnt_idx];

  assign res_hs = result_valid_o && result_ready_i;
  assign drop   = gnt_vld && !legit;
  assign stall  = result_valid_o && !result_ready_i;

  // Granted source is released on a core handshake or a drop.
  always_comb begin
    cp_result_ready_o = '0;
    if (res_hs || drop) cp_result_ready_o[gnt_idx] = 1'b1;
  end

  // Outstanding table; a set overrides a clear of the same ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ot_q <= '0;
    end else if (flush_i) begin
      ot_q <= '0;
    end else begin
      if (res_hs) ot_q[src_id].valid <= 1'b0;
      if (set_en) begin
        ot_q[id_q].valid <= 1'b1;
        ot_q[id_q].owner <= OwnerW'(k_q);
      end
    end
  end

  // Sticky flag for results that did not match the table.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) spurious_o <= 1'b0;
    else if (drop) spurious_o <= 1'b1;
  end

`ifdef CVXIF_ARB_PERF_EN
  logic [15:0] acc_cnt_q;
  logic [15:0] rej_cnt_q;

  // Saturating counters bumped on each issue response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else if (issue_ready_o) begin
      if (acc_q) begin
        if (acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
      end else begin
        if (rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
      end
    end
  end

  assign perf_accept_cnt_o = acc_cnt_q;
  assign perf_reject_cnt_o = rej_cnt_q;
`else
  assign perf_accept_cnt_o = '0;
  assign perf_reject_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cvxif_coproc_arbiter.sv
// tb_cvxif_coproc_arbiter: scoreboard bench for the coprocessor arbiter.
// Issue and result expectations are queued and checked by monitors.
module tb_cvxif_coproc_arbiter;

  localparam int N  = 2;
  localparam int IW = 3;
  localparam int XL = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic                   issue_valid_i = 1'b0;
  logic                   issue_ready_o;
  logic [31:0]            issue_instr_i = '0;
  logic [IW-1:0]          issue_id_i = '0;
  logic                   issue_accept_o;
  logic                   issue_writeback_o;
  logic [N-1:0]           cp_issue_valid_o;
  logic [N-1:0]           cp_issue_ready_i;
  logic [N-1:0]           cp_issue_accept_i;
  logic [N-1:0]           cp_issue_writeback_i;
  logic [31:0]            cp_issue_instr_o;
  logic [IW-1:0]          cp_issue_id_o;
  logic [N-1:0]           cp_result_valid_i = '0;
  logic [N-1:0]           cp_result_ready_o;
  logic [N-1:0][IW-1:0]   cp_result_id_i = '0;
  logic [N-1:0][XL-1:0]   cp_result_data_i = '0;
  logic [N-1:0][4:0]      cp_result_rd_i = '0;
  logic [N-1:0]           cp_result_we_i = '0;
  logic                   result_valid_o;
  logic                   result_ready_i = 1'b1;
  logic [IW-1:0]          result_id_o;
  logic [XL-1:0]          result_data_o;
  logic [4:0]             result_rd_o;
  logic                   result_we_o;
  logic                   spurious_o;
  logic [15:0]            perf_accept_cnt_o;
  logic [15:0]            perf_reject_cnt_o;

  logic [N-1:0] cp_rdy_mask = '1;
  logic [N-1:0] cp_acc = '0;
  logic [N-1:0] cp_wb = '0;
  assign cp_issue_ready_i     = cp_issue_valid_o & cp_rdy_mask;
  assign cp_issue_accept_i    = cp_acc;
  assign cp_issue_writeback_i = cp_wb;

  cvxif_coproc_arbiter #(
    .NrCoproc (N),
    .IdWidth  (IW),
    .XLEN     (XL)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .flush_i              (flush),
    .issue_valid_i        (issue_valid_i),
    .issue_ready_o        (issue_ready_o),
    .issue_instr_i        (issue_instr_i),
    .issue_id_i           (issue_id_i),
    .issue_accept_o       (issue_accept_o),
    .issue_writeback_o    (issue_writeback_o),
    .cp_issue_valid_o     (cp_issue_valid_o),
    .cp_issue_ready_i     (cp_issue_ready_i),
    .cp_issue_accept_i    (cp_issue_accept_i),
    .cp_issue_writeback_i (cp_issue_writeback_i),
    .cp_issue_instr_o     (cp_issue_instr_o),
    .cp_issue_id_o        (cp_issue_id_o),
    .cp_result_valid_i    (cp_result_valid_i),
    .cp_result_ready_o    (cp_result_ready_o),
    .cp_result_id_i       (cp_result_id_i),
    .cp_result_data_i     (cp_result_data_i),
    .cp_result_rd_i       (cp_result_rd_i),
    .cp_result_we_i       (cp_result_we_i),
    .result_valid_o       (result_valid_o),
    .result_ready_i       (result_ready_i),
    .result_id_o          (result_id_o),
    .result_data_o        (result_data_o),
    .result_rd_o          (result_rd_o),
    .result_we_o          (result_we_o),
    .spurious_o           (spurious_o),
    .perf_accept_cnt_o    (perf_accept_cnt_o),
    .perf_reject_cnt_o    (perf_reject_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic acc;
    logic wb;
    int   lat;
  } iexp_t;

  typedef struct {
    int          src;
    logic [IW-1:0] id;
    logic [XL-1:0] data;
    logic [4:0]  rd;
    logic        we;
  } res_t;

  iexp_t iq[$];
  res_t  rq[$];
  int    dq[$];
  res_t  srcq[N][$];
  int    issue_start = 0;
  logic [31:0]   cur_instr = '0;
  logic [IW-1:0] cur_id = '0;
  logic          saw_cp_valid = 1'b0;

  function automatic res_t mkres(input int src, input logic [IW-1:0] id);
    res_t r;
    r.src  = src;
    r.id   = id;
    r.data = {32'hC0DE_0000 + 32'(src), 29'd0, id};
    r.rd   = {2'b10, id};
    r.we   = ~id[0];
    return r;
  endfunction

  task automatic push_res(input int src, input logic [IW-1:0] id,
                          input bit legit);
    res_t r;
    r = mkres(src, id);
    srcq[src].push_back(r);
    if (legit) rq.push_back(r);
    else dq.push_back(src);
  endtask

  task automatic do_issue(input logic [IW-1:0] id, input logic a,
                          input logic w, input int lat);
    bit got;
    iq.push_back('{a, w, lat});
    @(negedge clk);
    cur_id        = id;
    cur_instr     = {16'hABCD, 13'd0, id};
    issue_id_i    = id;
    issue_instr_i = cur_instr;
    issue_valid_i = 1'b1;
    issue_start   = cyc;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (issue_ready_o) got = 1;
    end
    issue_valid_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout id %0d: got no ready, expected ready", id);
      void'(iq.pop_back());
    end
  endtask

  task automatic drain(input int bound);
    bit done;
    done = 0;
    for (int n = 0; n < bound && !done; n++) begin
      @(negedge clk);
      if (rq.size() == 0 && dq.size() == 0 &&
          srcq[0].size() == 0 && srcq[1].size() == 0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d left, expected 0/0",
               rq.size(), dq.size());
    end
  endtask

  // Result sources: hold the head item until it is handshaken.
  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      #4;
      hs = cp_result_valid_i & cp_result_ready_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          cp_result_valid_i[i] = 1'b1;
          cp_result_id_i[i]    = srcq[i][0].id;
          cp_result_data_i[i]  = srcq[i][0].data;
          cp_result_rd_i[i]    = srcq[i][0].rd;
          cp_result_we_i[i]    = srcq[i][0].we;
        end else begin
          cp_result_valid_i[i] = 1'b0;
        end
      end
    end
  end

  // Issue monitor.
  always @(negedge clk) begin
    iexp_t e;
    #4;
    if (rst_n) begin
      if (cp_issue_valid_o != '0) begin
        saw_cp_valid = 1'b1;
        chk("cp_issue_id", 64'(cp_issue_id_o), 64'(cur_id));
        chk("cp_issue_instr", 64'(cp_issue_instr_o), 64'(cur_instr));
        if ($countones(cp_issue_valid_o) > 1)
          chk("cp_issue_onehot", 64'(cp_issue_valid_o), 64'd0);
      end
      if (issue_ready_o) begin
        if (iq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got ready=1, expected 0");
        end else begin
          e = iq.pop_front();
          chk("issue_accept", 64'(issue_accept_o), 64'(e.acc));
          chk("issue_wb", 64'(issue_writeback_o), 64'(e.wb));
          chk("issue_latency", 64'(cyc - issue_start + 1), 64'(e.lat));
        end
      end else if (issue_accept_o || issue_writeback_o) begin
        chk("issue_idle_flags",
            64'({issue_accept_o, issue_writeback_o}), 64'd0);
      end
    end
  end

  // Result monitor: forwarded results and dropped results.
  always @(negedge clk) begin
    res_t e;
    logic [N-1:0] v;
    int s;
    #4;
    if (rst_n) begin
      if (result_valid_o) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got id %0d, expected none",
                   result_id_o);
        end else begin
          e = rq[0];
          v = '0;
          v[e.src] = 1'b1;
          if (!result_ready_i) v = '0;
          chk("res_id", 64'(result_id_o), 64'(e.id));
          chk("res_data", result_data_o, e.data);
          chk("res_rd", 64'(result_rd_o), 64'(e.rd));
          chk("res_we", 64'(result_we_o), 64'(e.we));
          chk("res_src_ready", 64'(cp_result_ready_o), 64'(v));
          if (result_ready_i) void'(rq.pop_front());
        end
      end else if (cp_result_ready_o != '0) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drop_unexpected: got ready %b, expected none",
                   cp_result_ready_o);
        end else begin
          s = dq.pop_front();
          v = '0;
          v[s] = 1'b1;
          chk("drop_src_ready", 64'(cp_result_ready_o), 64'(v));
        end
      end
    end
  end

  initial begin
`ifdef CVXIF_ARB_PERF_EN
    #10ms;
`else
    #500us;
`endif
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
    chk("rst_cp_issue_valid", 64'(cp_issue_valid_o), 64'd0);
    chk("rst_result_valid", 64'(result_valid_o), 64'd0);
    chk("rst_cp_result_ready", 64'(cp_result_ready_o), 64'd0);
    chk("rst_spurious", 64'(spurious_o), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cp_acc = 2'b10;
    cp_wb  = 2'b10;
    do_issue(3'd5, 1'b1, 1'b1, 4);

    cp_acc = 2'b00;
    do_issue(3'd0, 1'b0, 1'b0, 4);

    cp_acc = 2'b01;
    cp_wb  = 2'b01;
    do_issue(3'd4, 1'b1, 1'b1, 3);
    saw_cp_valid = 1'b0;
    do_issue(3'd4, 1'b0, 1'b0, 2);
    chk("dup_no_cp_valid", 64'(saw_cp_valid), 64'd0);

    do_issue(3'd0, 1'b1, 1'b1, 3);
    chk("spurious_clear", 64'(spurious_o), 64'd0);

    do_issue(3'd3, 1'b1, 1'b1, 3);
    push_res(1, 3'd3, 0);
    drain(20);
    chk("spurious_set", 64'(spurious_o), 64'd1);

    cp_acc = 2'b10;
    cp_wb  = 2'b00;
    do_issue(3'd2, 1'b1, 1'b0, 4);
    cp_acc = 2'b01;
    do_issue(3'd1, 1'b1, 1'b0, 3);

    @(negedge clk);
    result_ready_i = 1'b0;
    push_res(0, 3'd1, 1);
    push_res(1, 3'd2, 1);
    push_res(0, 3'd3, 1);
    push_res(1, 3'd5, 1);
    repeat (5) @(negedge clk);
    result_ready_i = 1'b1;
    drain(40);
    push_res(0, 3'd4, 1);
    push_res(0, 3'd0, 1);
    drain(40);

    do_issue(3'd6, 1'b1, 1'b0, 3);
    cp_rdy_mask = 2'b00;
    @(negedge clk);
    cur_id        = 3'd7;
    cur_instr     = {16'hABCD, 13'd0, 3'd7};
    issue_id_i    = 3'd7;
    issue_instr_i = cur_instr;
    issue_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("probe_k0_valid", 64'(cp_issue_valid_o), 64'd1);
    flush         = 1'b1;
    issue_valid_i = 1'b0;
    #1;
    chk("flush_cp_valid", 64'(cp_issue_valid_o), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("post_flush_cp_valid", 64'(cp_issue_valid_o), 64'd0);
      chk("post_flush_ready", 64'(issue_ready_o), 64'd0);
      @(negedge clk);
    end
    cp_rdy_mask = 2'b11;
    push_res(0, 3'd6, 0);
    drain(20);
    do_issue(3'd6, 1'b1, 1'b0, 3);
    push_res(0, 3'd6, 1);
    drain(20);

`ifdef CVXIF_ARB_PERF_EN
    for (int n = 0; n < 70000; n++) begin
      do_issue(3'd6, 1'b1, 1'b0, 3);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    chk("perf_accept_sat", 64'(perf_accept_cnt_o), 64'hFFFF);
`else
    chk("perf_accept_tied", 64'(perf_accept_cnt_o), 64'd0);
    chk("perf_reject_tied", 64'(perf_reject_cnt_o), 64'd0);
`endif

    repeat (3) @(negedge clk);
    if (iq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL issue_leftover: got %0d, expected 0", iq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvxif_coproc_arbiter.md
CVXIF_COPROC_ARBITER -- requirements
Module: cvxif_coproc_arbiter

Interface
REQ-001 SHALL have parameter NrCoproc, default 2, number of attached coprocessors (range 2..4).
REQ-002 SHALL have parameter IdWidth, default 3, instruction-ID width.
REQ-003 SHALL have parameter XLEN, default 64, result data width.
REQ-004 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  in  1  abort probe in progress, clear outstanding table.
REQ-007 SHALL have core issue ports: issue_valid_i in 1; issue_ready_o out 1; issue_instr_i in 32; issue_id_i in IdWidth; issue_accept_o out 1; issue_writeback_o out 1.
REQ-008 SHALL have coprocessor issue ports: cp_issue_valid_o out NrCoproc; cp_issue_ready_i in NrCoproc; cp_issue_accept_i in NrCoproc; cp_issue_writeback_i in NrCoproc; cp_issue_instr_o out 32; cp_issue_id_o out IdWidth.
REQ-009 SHALL have coprocessor result ports: cp_result_valid_i in NrCoproc; cp_result_ready_o out NrCoproc; cp_result_id_i in NrCoproc x IdWidth; cp_result_data_i in NrCoproc x XLEN; cp_result_rd_i in NrCoproc x 5; cp_result_we_i in NrCoproc.
REQ-010 SHALL have core result ports: result_valid_o out 1; result_ready_i in 1; result_id_o out IdWidth; result_data_o out XLEN; result_rd_o out 5; result_we_o out 1.
REQ-011 SHALL have spurious_o  out 1  sticky flag, result from non-owner or non-outstanding ID.

Function
REQ-012 Issue FSM SHALL have states IDLE, PROBE, RESP.
REQ-013 IDLE: on issue_valid_i, latch instr/ID, probe index k=0, go PROBE; if ID already outstanding, go RESP with accept=0 directly.
REQ-014 PROBE: assert only cp_issue_valid_o[k] with latched instr/ID; on cp_issue_ready_i[k]: accept -> record ID owner=k, go RESP(accept=1, writeback=cp_issue_writeback_i[k]); reject and k<NrCoproc-1 -> k+1; reject and k=NrCoproc-1 -> RESP(accept=0, writeback=0).
REQ-015 RESP: issue_ready_o=1 for exactly one cycle with issue_accept_o/issue_writeback_o valid, then IDLE; minimum issue latency 3 cycles (latch, probe, resp).
REQ-016 issue_accept_o, issue_writeback_o SHALL be 0 whenever issue_ready_o=0.
REQ-017 Outstanding table: 2^IdWidth entries of {valid, owner index}; set on accept in PROBE, cleared on core result handshake for that ID.
REQ-018 Result arbitration SHALL be round-robin over cp_result_valid_i, priority starting after last granted index; reset pointer selects index 0 first.
REQ-019 Grant SHALL be locked while result_valid_o=1 and result_ready_i=0; fields stable during stall.
REQ-020 Core handshake (result_valid_o & result_ready_i) SHALL assert cp_result_ready_o[grant] same cycle (combinational) and clear table entry.
REQ-021 Result whose ID is not outstanding or whose owner differs from the source SHALL be dropped: cp_result_ready_o asserted, not forwarded, spurious_o set.
REQ-022 Table set (issue) and clear (result) of different IDs in one cycle SHALL both take effect.
REQ-023 flush_i SHALL force FSM to IDLE next cycle without RESP, deassert cp_issue_valid_o, clear all table entries; result arbiter unaffected, except the results that follow become spurious.

Reset
REQ-024 On rst_ni low: FSM IDLE, k=0, table cleared, RR pointer 0, spurious_o=0, all valid/ready outputs 0; reset mid-probe abandons the instruction with no response.

Configuration
REQ-025 With macro CVXIF_ARB_PERF_EN defined, SHALL add outputs perf_accept_cnt_o and perf_reject_cnt_o, 16-bit, saturating at 16'hFFFF, incremented in RESP, cleared by reset.
REQ-026 Without CVXIF_ARB_PERF_EN, both ports SHALL exist and be tied to 0, with no counter flops.

Structure
REQ-027 Package cvxif_arb_pkg SHALL hold the FSM state enum and the outstanding-entry struct typedef.
REQ-028 Result round-robin with lock SHALL be sub-module cvxif_result_rr.

Verification
REQ-029 NrCoproc=2: cp0 rejects, cp1 accepts ID 5 -> issue_ready_o at cycle 4, accept=1, table[5].owner=1.
REQ-030 Both coprocessors reject -> issue_ready_o with accept=0, writeback=0, table unchanged.
REQ-031 Both raise results (IDs 1, 2) continuously, result_ready_i=1 -> alternating grants cp0, cp1; with result_ready_i=0 for 3 cycles, grant and data held.
REQ-032 cp1 returns ID 3 owned by cp0 -> dropped, cp_result_ready_o[1]=1, spurious_o=1, result_valid_o=0.
REQ-033 Issue ID 4 while ID 4 outstanding -> no cp_issue_valid_o, accept=0 response.
REQ-034 flush_i during PROBE -> IDLE next cycle, no issue_ready_o pulse, table empty; with CVXIF_ARB_PERF_EN, 70000 accepts -> perf_accept_cnt_o=16'hFFFF.
